// File: rtl/laser_pkg.sv
// ---------------------------------------------------------------------------
// laser_pkg
// Shared definitions for the two-circle laser coverage optimiser:
//   - default values for the grid width, point count, squared radius and
//     the round limit
//   - the controller state encoding
// ---------------------------------------------------------------------------
package laser_pkg;

    localparam int DEF_COORD_W   = 4;
    localparam int DEF_NUM_PTS   = 40;
    localparam int DEF_R2        = 16;
    localparam int DEF_MAX_ROUND = 4;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        SCAN1  = 2'd1,
        SCAN2  = 2'd2,
        FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/laser_cover_cnt.sv
// ---------------------------------------------------------------------------
// laser_cover_cnt
// Purely combinational union popcount: counts how many of the NUM_PTS points
// lie inside the candidate circle or inside the other circle (the latter
// only when other_en is set). A point is inside when dx^2+dy^2 <= R2.
//
// Ports
//   cand_x, cand_y   in   candidate centre
//   other_x, other_y in   the other (fixed) centre
//   other_en         in   1 = other circle contributes coverage
//   pts_x, pts_y     in   packed point arrays, NUM_PTS entries each
//   count            out  number of points covered by the union
// ---------------------------------------------------------------------------
module laser_cover_cnt
    import laser_pkg::*;
#(
    parameter int COORD_W = DEF_COORD_W,
    parameter int NUM_PTS = DEF_NUM_PTS,
    parameter int R2      = DEF_R2
) (
    input  logic [COORD_W-1:0]              cand_x,
    input  logic [COORD_W-1:0]              cand_y,
    input  logic [COORD_W-1:0]              other_x,
    input  logic [COORD_W-1:0]              other_y,
    input  logic                            other_en,
    input  logic [NUM_PTS-1:0][COORD_W-1:0] pts_x,
    input  logic [NUM_PTS-1:0][COORD_W-1:0] pts_y,
    output logic [$clog2(NUM_PTS+1)-1:0]    count
);

    localparam int CNT_W = $clog2(NUM_PTS+1);
    // Two squares of COORD_W-bit values plus one carry bit: never wraps.
    localparam int SQ_W  = 2*COORD_W + 1;
    // A radius larger than any reachable distance saturates to all-ones.
    localparam logic [SQ_W-1:0] R2_V = (R2 >= (1 << SQ_W)) ? {SQ_W{1'b1}} : SQ_W'(R2);

    function automatic logic in_radius(
        input logic [COORD_W-1:0] ax,
        input logic [COORD_W-1:0] ay,
        input logic [COORD_W-1:0] bx,
        input logic [COORD_W-1:0] by
    );
        logic [COORD_W-1:0] dx;
        logic [COORD_W-1:0] dy;
        logic [SQ_W-1:0]    d2;
        dx = (ax >= bx) ? (ax - bx) : (bx - ax);
        dy = (ay >= by) ? (ay - by) : (by - ay);
        d2 = SQ_W'(dx) * SQ_W'(dx) + SQ_W'(dy) * SQ_W'(dy);
        return (d2 <= R2_V);
    endfunction

    logic [NUM_PTS-1:0] hit;

    for (genvar gi = 0; gi < NUM_PTS; gi++) begin : g_pt
        assign hit[gi] = in_radius(cand_x, cand_y, pts_x[gi], pts_y[gi])
                       | (other_en & in_radius(other_x, other_y, pts_x[gi], pts_y[gi]));
    end

    always_comb begin
        count = '0;
        for (int i = 0; i < NUM_PTS; i++) begin
            count = count + CNT_W'(hit[i]);
        end
    end

endmodule

// File: rtl/laser_multi.sv
// ---------------------------------------------------------------------------
// laser_multi
// Loads NUM_PTS points, then alternately sweeps every grid position as a new
// centre for circle 1 (SCAN1) and circle 2 (SCAN2), keeping a candidate only
// when it strictly improves union coverage. Rounds repeat until a round adds
// nothing or MAX_ROUND rounds are done; the result is then published with a
// one-cycle DONE pulse and the block returns to LOAD for the next pattern.
//
// Ports
//   CLK              in   clock, rising edge
//   RST              in   synchronous active-low reset
//   IN_VALID         in   X/Y hold a point to store (LOAD only)
//   X, Y             in   point coordinates
//   C1X, C1Y         out  circle 1 centre of the last result
//   C2X, C2Y         out  circle 2 centre of the last result
//   COVER            out  points covered by the last result
//   DONE             out  one-cycle pulse, result just updated
// ---------------------------------------------------------------------------
module laser_multi
    import laser_pkg::*;
#(
    parameter int COORD_W   = DEF_COORD_W,
    parameter int NUM_PTS   = DEF_NUM_PTS,
    parameter int R2        = DEF_R2,
    parameter int MAX_ROUND = DEF_MAX_ROUND
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         IN_VALID,
    input  logic [COORD_W-1:0]           X,
    input  logic [COORD_W-1:0]           Y,
    output logic [COORD_W-1:0]           C1X,
    output logic [COORD_W-1:0]           C1Y,
    output logic [COORD_W-1:0]           C2X,
    output logic [COORD_W-1:0]           C2Y,
    output logic [$clog2(NUM_PTS+1)-1:0] COVER,
    output logic                         DONE
);

    localparam int CNT_W   = $clog2(NUM_PTS+1);
    localparam int IDX_W   = (NUM_PTS > 1) ? $clog2(NUM_PTS) : 1;
    localparam int CAND_W  = 2*COORD_W;
    localparam int ROUND_W = $clog2(MAX_ROUND+1);

    localparam logic [IDX_W-1:0]   LAST_PT    = IDX_W'(NUM_PTS-1);
    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(MAX_ROUND-1);

    state_t                          state_reg;
    logic [IDX_W-1:0]                pt_idx_reg;
    logic [CAND_W-1:0]               cand_reg;
    logic [ROUND_W-1:0]              round_reg;
    logic [COORD_W-1:0]              c1x_reg, c1y_reg, c2x_reg, c2y_reg;
    logic [CNT_W-1:0]                cov_reg;
    logic [CNT_W-1:0]                round_cov_reg;   // coverage at start of round
    logic [COORD_W-1:0]              c1x_out_reg, c1y_out_reg, c2x_out_reg, c2y_out_reg;
    logic [CNT_W-1:0]                cover_out_reg;
    logic                            done_reg;

    logic [NUM_PTS-1:0][COORD_W-1:0] pts_x_reg, pts_y_reg;

    logic [COORD_W-1:0]              cand_x, cand_y;
    logic [COORD_W-1:0]              other_x, other_y;
    logic                            other_en;
    logic [CNT_W-1:0]                score;
    logic                            better;
    logic [CNT_W-1:0]                cov_next;
    logic [COORD_W-1:0]              c2x_next, c2y_next;
    logic                            last_cand;
    logic                            load_wr;

    // y-major, x-minor sweep order.
    assign cand_x    = cand_reg[COORD_W-1:0];
    assign cand_y    = cand_reg[CAND_W-1:COORD_W];
    assign last_cand = &cand_reg;

    // SCAN1 moves circle 1 against circle 2 (which is inert in round 1);
    // SCAN2 moves circle 2 against circle 1.
    always_comb begin
        other_x  = c2x_reg;
        other_y  = c2y_reg;
        other_en = (round_reg != '0);
        if (state_reg == SCAN2) begin
            other_x  = c1x_reg;
            other_y  = c1y_reg;
            other_en = 1'b1;
        end
    end

    laser_cover_cnt #(
        .COORD_W (COORD_W),
        .NUM_PTS (NUM_PTS),
        .R2      (R2)
    ) u_cover_cnt (
        .cand_x   (cand_x),
        .cand_y   (cand_y),
        .other_x  (other_x),
        .other_y  (other_y),
        .other_en (other_en),
        .pts_x    (pts_x_reg),
        .pts_y    (pts_y_reg),
        .count    (score)
    );

    // Strictly greater: ties keep the earliest candidate / existing centre.
    assign better   = ((state_reg == SCAN1) || (state_reg == SCAN2)) && (score > cov_reg);
    assign cov_next = better ? score  : cov_reg;
    assign c2x_next = better ? cand_x : c2x_reg;
    assign c2y_next = better ? cand_y : c2y_reg;

    // Point memory: no reset, one write port addressed by the load index.
    assign load_wr = RST && (state_reg == LOAD) && IN_VALID;

    for (genvar gi = 0; gi < NUM_PTS; gi++) begin : g_mem
        always_ff @(posedge CLK) begin
            if (load_wr && (pt_idx_reg == IDX_W'(gi))) begin
                pts_x_reg[gi] <= X;
                pts_y_reg[gi] <= Y;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_reg     <= LOAD;
            pt_idx_reg    <= '0;
            cand_reg      <= '0;
            round_reg     <= '0;
            c1x_reg       <= '0;
            c1y_reg       <= '0;
            c2x_reg       <= '0;
            c2y_reg       <= '0;
            cov_reg       <= '0;
            round_cov_reg <= '0;
            c1x_out_reg   <= '0;
            c1y_out_reg   <= '0;
            c2x_out_reg   <= '0;
            c2y_out_reg   <= '0;
            cover_out_reg <= '0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                LOAD: begin
                    if (IN_VALID) begin
                        if (pt_idx_reg == LAST_PT) begin
                            // Fresh working state for this pattern.
                            pt_idx_reg    <= '0;
                            cand_reg      <= '0;
                            round_reg     <= '0;
                            c1x_reg       <= '0;
                            c1y_reg       <= '0;
                            c2x_reg       <= '0;
                            c2y_reg       <= '0;
                            cov_reg       <= '0;
                            round_cov_reg <= '0;
                            state_reg     <= SCAN1;
                        end else begin
                            pt_idx_reg <= pt_idx_reg + IDX_W'(1);
                        end
                    end
                end
                SCAN1: begin
                    if (better) begin
                        c1x_reg <= cand_x;
                        c1y_reg <= cand_y;
                    end
                    cov_reg  <= cov_next;
                    cand_reg <= cand_reg + CAND_W'(1);   // wraps to 0 for SCAN2
                    if (last_cand) begin
                        state_reg <= SCAN2;
                    end
                end
                SCAN2: begin
                    c2x_reg  <= c2x_next;
                    c2y_reg  <= c2y_next;
                    cov_reg  <= cov_next;
                    cand_reg <= cand_reg + CAND_W'(1);
                    if (last_cand) begin
                        round_reg     <= round_reg + ROUND_W'(1);
                        round_cov_reg <= cov_next;
                        if ((cov_next == round_cov_reg) || (round_reg >= LAST_ROUND)) begin
                            // Publish including this final candidate's update.
                            state_reg     <= FINISH;
                            done_reg      <= 1'b1;
                            c1x_out_reg   <= c1x_reg;
                            c1y_out_reg   <= c1y_reg;
                            c2x_out_reg   <= c2x_next;
                            c2y_out_reg   <= c2y_next;
                            cover_out_reg <= cov_next;
                        end else begin
                            state_reg <= SCAN1;
                        end
                    end
                end
                FINISH: begin
                    state_reg  <= LOAD;
                    pt_idx_reg <= '0;
                end
                default: begin
                    state_reg <= LOAD;
                end
            endcase
        end
    end

    assign C1X   = c1x_out_reg;
    assign C1Y   = c1y_out_reg;
    assign C2X   = c2x_out_reg;
    assign C2Y   = c2y_out_reg;
    assign COVER = cover_out_reg;
    assign DONE  = done_reg;

endmodule

// File: tb/tb_laser_multi.sv
// ---------------------------------------------------------------------------
// tb_laser_multi
// Scoreboard bench for laser_multi with default parameters. The driver loads
// directed point patterns and pushes the hand-computed result (centres,
// coverage and the cycle DONE must appear on) into a queue; an independent
// monitor pops and compares on every DONE, and between DONEs checks that the
// published outputs hold the last expected result.
// ---------------------------------------------------------------------------
module tb_laser_multi;

    localparam int NUM      = 40;
    localparam int SCAN_RUN = 1024;   // two rounds of two 256-cycle scans

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       IN_VALID = 1'b0;
    logic [3:0] X = 4'd0;
    logic [3:0] Y = 4'd0;
    logic [3:0] C1X, C1Y, C2X, C2Y;
    logic [5:0] COVER;
    logic       DONE;

    laser_multi dut (
        .CLK      (CLK),
        .RST      (RST),
        .IN_VALID (IN_VALID),
        .X        (X),
        .Y        (Y),
        .C1X      (C1X),
        .C1Y      (C1Y),
        .C2X      (C2X),
        .C2Y      (C2Y),
        .COVER    (COVER),
        .DONE     (DONE)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int c1x;
        int c1y;
        int c2x;
        int c2y;
        int cov;
        int done_cyc;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;
    int hold_val = 0;
    bit mon_en   = 1'b0;
    bit prev_done = 1'b0;

    logic [3:0] pat_x [NUM];
    logic [3:0] pat_y [NUM];

    function automatic int pack5(input int a, input int b, input int c, input int d, input int e);
        return (a << 18) | (b << 14) | (c << 10) | (d << 6) | e;
    endfunction

    task automatic chk(input string name, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic set_same(input int x, input int y);
        for (int i = 0; i < NUM; i++) begin
            pat_x[i] = 4'(x);
            pat_y[i] = 4'(y);
        end
    endtask

    task automatic set_split();
        for (int i = 0; i < NUM; i++) begin
            pat_x[i] = (i < 20) ? 4'd2 : 4'd12;
            pat_y[i] = (i < 20) ? 4'd2 : 4'd12;
        end
    endtask

    // toggle: IN_VALID alternates 1,0,... ; junk: IN_VALID stays high with
    // a stray point during the scans (must be ignored).
    task automatic load(input bit toggle, input bit junk, input bit expect_it,
                        input int e1x, input int e1y, input int e2x, input int e2y,
                        input int ecov);
        exp_t e;
        int   start;
        for (int i = 0; i < NUM; i++) begin
            @(negedge CLK);
            if (i == 0) begin
                start = cyc;
                if (expect_it) begin
                    e.c1x = e1x;
                    e.c1y = e1y;
                    e.c2x = e2x;
                    e.c2y = e2y;
                    e.cov = ecov;
                    e.done_cyc = start + (toggle ? 79 : 40) + SCAN_RUN;
                    exp_q.push_back(e);
                end
            end
            IN_VALID = 1'b1;
            X = pat_x[i];
            Y = pat_y[i];
            if (toggle && i != NUM-1) begin
                @(negedge CLK);
                IN_VALID = 1'b0;
                X = 4'hF;
                Y = 4'h0;
            end
        end
        @(negedge CLK);
        if (junk) begin
            IN_VALID = 1'b1;
            X = 4'd0;
            Y = 4'd0;
        end else begin
            IN_VALID = 1'b0;
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge CLK);
            #2;
            n++;
        end
        IN_VALID = 1'b0;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: %0d results outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_done"},  int'(DONE),  0);
        chk({tag, "_c1x"},   int'(C1X),   0);
        chk({tag, "_c1y"},   int'(C1Y),   0);
        chk({tag, "_c2x"},   int'(C2X),   0);
        chk({tag, "_c2y"},   int'(C2Y),   0);
        chk({tag, "_cover"}, int'(COVER), 0);
    endtask

    // Monitor: samples 1 time unit after the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            #1;
            if (DONE) begin
                n_done++;
                $display("result %0d: c1=(%0d,%0d) c2=(%0d,%0d) cover=%0d cycle=%0d",
                         n_done, C1X, C1Y, C2X, C2Y, COVER, cyc);
                chk("done_pulse", int'(prev_done), 0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got DONE at cycle %0d, expected none", cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("c1x",        int'(C1X),   e.c1x);
                    chk("c1y",        int'(C1Y),   e.c1y);
                    chk("c2x",        int'(C2X),   e.c2x);
                    chk("c2y",        int'(C2Y),   e.c2y);
                    chk("cover",      int'(COVER), e.cov);
                    chk("done_cycle", cyc,         e.done_cyc);
                    hold_val = pack5(e.c1x, e.c1y, e.c2x, e.c2y, e.cov);
                end
            end else if (mon_en) begin
                chk("hold_outputs", pack5(int'(C1X), int'(C1Y), int'(C2X), int'(C2Y), int'(COVER)),
                    hold_val);
            end
            prev_done = DONE;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Power-on reset.
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        check_zero("reset");
        RST = 1'b1;
        hold_val = 0;
        mon_en = 1'b1;

        // All points at (3,3): (0,0) is at 18 > 16, (1,0) at 13 wins.
        set_same(3, 3);
        load(1'b0, 1'b0, 1'b1, 1, 0, 0, 0, 40);
        wait_done();

        // Back-to-back: two clusters; circle 2 lands on (12,8) (distance 16).
        set_split();
        load(1'b0, 1'b0, 1'b1, 0, 0, 12, 8, 40);
        wait_done();

        // (3,3) again with IN_VALID toggling: DONE 39 cycles later.
        set_same(3, 3);
        load(1'b1, 1'b0, 1'b1, 1, 0, 0, 0, 40);
        wait_done();

        // Corner cluster at (15,15): first hit is (15,11) exactly on R2;
        // IN_VALID held high with (0,0) during the scans must be ignored.
        set_same(15, 15);
        load(1'b0, 1'b1, 1'b1, 15, 11, 0, 0, 40);
        wait_done();

        // Reset mid-scan (SCAN2 candidate 100), then reload and finish.
        set_split();
        load(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
        repeat (356) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check_zero("midrst");
        hold_val = 0;
        RST = 1'b1;
        load(1'b0, 1'b0, 1'b1, 0, 0, 12, 8, 40);
        wait_done();

        repeat (5) @(negedge CLK);
        chk("done_count", n_done, 5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/laser_multi.md
LASER_MULTI -- requirements
Module: laser_multi

Interface
REQ-001 Parameter COORD_W, default 4: coordinate width; grid is 2^COORD_W x 2^COORD_W.
REQ-002 Parameter NUM_PTS, default 40: points per pattern.
REQ-003 Parameter R2, default 16: squared coverage radius; a point is covered when dx^2+dy^2 <= R2.
REQ-004 Parameter MAX_ROUND, default 4: maximum optimisation rounds per pattern.
REQ-005 One clock; reset is synchronous and active-low.
REQ-006 CLK  input  1  clock, all state changes on rising edge.
REQ-007 RST  input  1  synchronous active-low reset.
REQ-008 IN_VALID  input  1  X/Y carry a valid point this cycle (new vs. previous generation).
REQ-009 X  input  COORD_W  point x coordinate.
REQ-010 Y  input  COORD_W  point y coordinate.
REQ-011 C1X, C1Y  output  COORD_W each  circle 1 centre result.
REQ-012 C2X, C2Y  output  COORD_W each  circle 2 centre result.
REQ-013 COVER  output  $clog2(NUM_PTS+1)  number of points covered by the result.
REQ-014 DONE  output  1  one-cycle pulse, result valid.

Function
REQ-015 States: LOAD, SCAN1, SCAN2, FINISH; state after reset is LOAD.
REQ-016 LOAD: X/Y stored at point index 0..NUM_PTS-1 on each edge with IN_VALID=1; IN_VALID=0 cycles store nothing and do not advance the index.
REQ-017 The edge storing point NUM_PTS-1 moves the FSM to SCAN1 with candidate index 0; IN_VALID is ignored outside LOAD.
REQ-018 Candidate index i in 0..2^(2*COORD_W)-1 maps to cx = i[COORD_W-1:0], cy = i[2*COORD_W-1:COORD_W] (y-major, x-minor); one candidate is evaluated per cycle, all NUM_PTS points in parallel.
REQ-019 Distance arithmetic uses absolute differences; squared sum carries 2*COORD_W+1 bits, so there is no overflow or wrap.
REQ-020 SCAN1: score = count of points covered by candidate or by current C2; SCAN2: score = count covered by current C1 or candidate.
REQ-021 The running best starts each scan at the current union coverage; a candidate replaces the scanned centre only when its score is strictly greater, so ties keep the earliest index or the existing centre.
REQ-022 In round 1 SCAN1, circle 2 is disabled and covers nothing; from SCAN2 of round 1 onward, both circles are active.
REQ-023 Working C1 and C2 start at (0,0) with coverage 0 at the start of every pattern.
REQ-024 Each scan lasts exactly 2^(2*COORD_W) cycles, then SCAN1 leads to SCAN2 and SCAN2 leads to SCAN1 or FINISH.
REQ-025 After SCAN2, the FSM enters FINISH if the round did not raise coverage or if MAX_ROUND rounds are complete; otherwise it starts another round in SCAN1.
REQ-026 FINISH lasts one cycle.
  - DONE=1 in that cycle.
  - C1X/C1Y/C2X/C2Y/COVER are loaded from the working registers on the edge entering FINISH and then held until the next FINISH.
  - The next state is LOAD with point index 0; no reset is needed between patterns.
REQ-027 DONE=0 in all states other than FINISH.

Reset
REQ-028 RST=0 sampled on an edge, in any state including mid-scan, forces LOAD, point index 0, candidate index 0, round count 0, and working centres (0,0).
REQ-029 The same reset drives C1X=C1Y=C2X=C2Y=0, COVER=0 and DONE=0; stored point memory need not be cleared.
REQ-030 Reset takes priority over IN_VALID and over every state transition in the same cycle.

Structure
REQ-031 Package laser_pkg holds the state enum and the default values of COORD_W, NUM_PTS, R2 and MAX_ROUND.
REQ-032 One combinational sub-module, laser_cover_cnt, takes a candidate centre, the other centre with its enable, and the point array, and returns the union popcount.
REQ-033 The top level holds the FSM, point storage, candidate and round counters, and best/result registers.

Verification
REQ-034 All 40 points at (3,3) with IN_VALID held high: DONE on the 1024th edge after the last point sample, C1=(1,0), C2=(0,0), COVER=40.
REQ-035 20 points at (2,2) and 20 points at (12,12): C1=(0,0), C2=(12,8), COVER=40, two rounds.
REQ-036 IN_VALID toggled 1,0,1,0 during load of the (3,3) pattern: same result as REQ-034; DONE shifted by 39 cycles.
REQ-037 RST=0 for 1 cycle at candidate 100 of SCAN2, then the REQ-035 pattern reloaded: DONE=0 and outputs 0 during reset; final result matches REQ-035.
REQ-038 Two patterns back-to-back without reset (REQ-034 then REQ-035): two DONE pulses; outputs hold the first result until the second FINISH.
REQ-039 Re-run of REQ-034 and REQ-035 with COORD_W=5, NUM_PTS=64, R2=25: each scan lasts 1024 cycles, and a full-coverage case reports COVER=64.
